// File: rtl/microcode_sequencer.sv
// ---------------------------------------------------------------------------
// microcode_sequencer
//
// Steps through the microcode of one instruction at a time. It holds the
// latched opcode and the per-instruction step counter, and both drive an
// external combinational lookup. Each clock it evaluates the returned word
// and issues it as a registered microcode word. A word can also stall on its
// wait sources, end the instruction, halt the CPU, or trip the runaway
// watchdog.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   run          permission to start / continue instructions
//   opcode_in    opcode from the instruction register
//   ucode_in     lookup result for (op_cur, cycle)
//   wait_en      per-source wait decode of ucode_in
//   busy         per-source busy flags
//   op_cur       latched opcode driving the lookup
//   cycle        current step index driving the lookup
//   ucode_out    issued microcode word (registered)
//   ucode_valid  ucode_out is valid this cycle
//   instr_done   one-cycle pulse after END_CODE is evaluated
//   stalled      current step is blocked by a wait condition
//   halted       HLT_CODE has been issued (sticky until reset)
//   fault        watchdog tripped (sticky until reset)
// ---------------------------------------------------------------------------
module microcode_sequencer #(
    parameter int             OPW       = 8,
    parameter int             UCW       = 6,
    parameter int             CYCW      = 6,
    parameter int             NWAIT     = 4,
    parameter logic [UCW-1:0] END_CODE  = UCW'(0),
    parameter logic [UCW-1:0] HLT_CODE  = UCW'(1),
    parameter int             MAX_STEPS = 48
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [OPW-1:0]   opcode_in,
    input  logic [UCW-1:0]   ucode_in,
    input  logic [NWAIT-1:0] wait_en,
    input  logic [NWAIT-1:0] busy,
    output logic [OPW-1:0]   op_cur,
    output logic [CYCW-1:0]  cycle,
    output logic [UCW-1:0]   ucode_out,
    output logic             ucode_valid,
    output logic             instr_done,
    output logic             stalled,
    output logic             halted,
    output logic             fault
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        HALT,
        FAULT
    } state_t;

    state_t          state_reg, state_next;
    logic [OPW-1:0]  op_cur_reg, op_cur_next;
    logic [CYCW-1:0] cycle_reg, cycle_next;
    logic [UCW-1:0]  ucode_out_reg, ucode_out_next;
    logic            ucode_valid_reg, ucode_valid_next;
    logic            instr_done_reg, instr_done_next;
    logic            halted_reg, halted_next;
    logic            fault_reg, fault_next;
    logic            stalled_int;

    // A source only blocks when the current word asks to wait on it.
    logic [NWAIT-1:0] blk_bits;
    logic             blk;

    generate
        for (genvar gi = 0; gi < NWAIT; gi++) begin : g_wait
            assign blk_bits[gi] = wait_en[gi] & busy[gi];
        end
    endgenerate

    assign blk = |blk_bits;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            op_cur_reg      <= '0;
            cycle_reg       <= '0;
            ucode_out_reg   <= END_CODE;
            ucode_valid_reg <= 1'b0;
            instr_done_reg  <= 1'b0;
            halted_reg      <= 1'b0;
            fault_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            op_cur_reg      <= op_cur_next;
            cycle_reg       <= cycle_next;
            ucode_out_reg   <= ucode_out_next;
            ucode_valid_reg <= ucode_valid_next;
            instr_done_reg  <= instr_done_next;
            halted_reg      <= halted_next;
            fault_reg       <= fault_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        op_cur_next      = op_cur_reg;
        cycle_next       = cycle_reg;
        ucode_out_next   = ucode_out_reg;
        ucode_valid_next = 1'b0;
        instr_done_next  = 1'b0;
        halted_next      = halted_reg;
        fault_next       = fault_reg;
        stalled_int      = 1'b0;

        case (state_reg)
            IDLE: begin
                cycle_next = '0;
                if (run) begin
                    op_cur_next = opcode_in;
                    state_next  = EXEC;
                end
            end

            EXEC: begin
                stalled_int = blk;
                if (ucode_in == END_CODE) begin
                    // END wins over any wait; the step is a single bubble.
                    // With run still high, the next opcode is latched on
                    // the same edge so no extra idle cycle is spent.
                    instr_done_next = 1'b1;
                    cycle_next      = '0;
                    if (run) begin
                        op_cur_next = opcode_in;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (ucode_in == HLT_CODE) begin
                    ucode_out_next   = HLT_CODE;
                    ucode_valid_next = 1'b1;
                    halted_next      = 1'b1;
                    state_next       = HALT;
                end else if (blk) begin
                    // Hold the step; the word issues once its sources clear.
                    cycle_next = cycle_reg;
                end else if (cycle_reg == CYCW'(MAX_STEPS)) begin
                    fault_next = 1'b1;
                    state_next = FAULT;
                end else begin
                    ucode_out_next   = ucode_in;
                    ucode_valid_next = 1'b1;
                    cycle_next       = cycle_reg + CYCW'(1);
                end
            end

            HALT: begin
                state_next = HALT;
            end

            FAULT: begin
                state_next = FAULT;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign op_cur      = op_cur_reg;
    assign cycle       = cycle_reg;
    assign ucode_out   = ucode_out_reg;
    assign ucode_valid = ucode_valid_reg;
    assign instr_done  = instr_done_reg;
    assign stalled     = stalled_int;
    assign halted      = halted_reg;
    assign fault       = fault_reg;

endmodule

// File: tb/tb_microcode_sequencer.sv
// ---------------------------------------------------------------------------
// tb_microcode_sequencer
//
// Bench for microcode_sequencer. The bench contains the microcode lookup
// table, so it answers (op_cur, cycle) combinationally. It covers a set of
// directed scenarios (sequence timing, stall, halt, watchdog, reset
// mid-instruction, run drop) and then a randomized phase. In the random
// phase every instruction's expected issued-word stream is queued on issue
// and a monitor pops and compares as words and done pulses appear.
// ---------------------------------------------------------------------------
module tb_microcode_sequencer;

    localparam int DONE_TOKEN = -1;

    logic       clk;
    logic       reset;
    logic       run;
    logic [7:0] opcode_in;
    logic [5:0] ucode_in;
    logic [3:0] wait_en;
    logic [3:0] busy;
    logic [7:0] op_cur;
    logic [5:0] cycle;
    logic [5:0] ucode_out;
    logic       ucode_valid;
    logic       instr_done;
    logic       stalled;
    logic       halted;
    logic       fault;

    int vec_count;
    int err_count;
    bit sb_on;
    bit rand_busy;
    int exp_q[$];

    // Random program store: opcode 0x4N runs program N.
    logic [5:0] pw [16][16];
    logic [3:0] pm [16][16];
    int         plen [16];

    microcode_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .opcode_in  (opcode_in),
        .ucode_in   (ucode_in),
        .wait_en    (wait_en),
        .busy       (busy),
        .op_cur     (op_cur),
        .cycle      (cycle),
        .ucode_out  (ucode_out),
        .ucode_valid(ucode_valid),
        .instr_done (instr_done),
        .stalled    (stalled),
        .halted     (halted),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Microcode lookup: directed opcodes are fixed, 0x4N are random programs.
    always_comb begin
        ucode_in = 6'd0;
        wait_en  = 4'd0;
        case (op_cur)
            8'h20: if (cycle < 6'd4) ucode_in = 6'd2 + cycle;
            8'h21: if (cycle == 6'd0) begin
                ucode_in = 6'd6;
                wait_en  = 4'b0001;
            end
            8'h22: if (cycle == 6'd0) ucode_in = 6'd9;
            8'h23: if (cycle < 6'd6) ucode_in = 6'd10 + cycle;
            8'h24: if (cycle < 6'd3) ucode_in = 6'd20 + cycle;
            8'h30: if (cycle == 6'd0) begin
                ucode_in = 6'd1;
                wait_en  = 4'b0001;
            end
            8'h31: ucode_in = 6'd7;
            default: begin
                if (op_cur[7:4] == 4'h4 && cycle < 6'd16) begin
                    ucode_in = pw[op_cur[3:0]][cycle[3:0]];
                    wait_en  = pm[op_cur[3:0]][cycle[3:0]];
                end
            end
        endcase
    end

    task automatic chk(input string name, input int got, input int exp);
        vec_count++;
        if (got !== exp) begin
            err_count++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        run       = 1'b0;
        busy      = 4'd0;
        opcode_in = 8'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Expected stream of one instruction: its words in order, then END.
    task automatic push_prog(input logic [7:0] op);
        int idx;
        idx = int'(op[3:0]);
        for (int s = 0; s < plen[idx]; s++) exp_q.push_back(int'(pw[idx][s]));
        exp_q.push_back(DONE_TOKEN);
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (instr_done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic monitor();
        int e;
        forever begin
            @(negedge clk);
            if (sb_on) begin
                if (ucode_valid || instr_done)
                    chk("sb_valid_done_exclusive", int'(ucode_valid & instr_done), 0);
                if (ucode_valid) begin
                    if (exp_q.size() == 0) chk("sb_unexpected_word", int'(ucode_out), DONE_TOKEN);
                    else begin
                        e = exp_q.pop_front();
                        chk("sb_word", int'(ucode_out), e);
                    end
                end
                if (instr_done) begin
                    if (exp_q.size() == 0) chk("sb_unexpected_done", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("sb_done_order", DONE_TOKEN, e);
                    end
                    chk("sb_no_fault", int'(fault | halted), 0);
                end
            end
        end
    endtask

    task automatic busy_driver();
        forever begin
            @(negedge clk);
            if (rand_busy) busy = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
        end
    endtask

    initial begin
        int a_v[7];
        int a_w[7];
        int a_d[7];
        int a_c[7];
        int nwords;
        logic [7:0] op;

        vec_count = 0;
        err_count = 0;
        sb_on     = 1'b0;
        rand_busy = 1'b0;
        reset     = 1'b1;
        run       = 1'b0;
        busy      = 4'd0;
        opcode_in = 8'd0;

        for (int i = 0; i < 16; i++) begin
            plen[i] = int'($urandom_range(0, 8));
            for (int s = 0; s < 16; s++) begin
                pw[i][s] = (s < plen[i]) ? 6'($urandom_range(2, 63)) : 6'd0;
                pm[i][s] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
            end
        end

        fork
            monitor();
            busy_driver();
        join_none

        // ---------------- reset state ----------------
        do_reset();
        chk("rst_op_cur", int'(op_cur), 0);
        chk("rst_cycle", int'(cycle), 0);
        chk("rst_ucode_out", int'(ucode_out), 0);
        chk("rst_valid", int'(ucode_valid), 0);
        chk("rst_done", int'(instr_done), 0);
        chk("rst_stalled", int'(stalled), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_fault", int'(fault), 0);

        // ---------------- A: 2,3,4,5,END then next opcode ----------------
        a_v = '{0, 1, 1, 1, 1, 0, 1};
        a_w = '{0, 2, 3, 4, 5, 0, 9};
        a_d = '{0, 0, 0, 0, 0, 1, 0};
        a_c = '{0, 1, 2, 3, 4, 0, 1};
        opcode_in = 8'h20;
        run       = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk($sformatf("seq_valid_%0d", k), int'(ucode_valid), a_v[k]);
            chk($sformatf("seq_done_%0d", k), int'(instr_done), a_d[k]);
            chk($sformatf("seq_cycle_%0d", k), int'(cycle), a_c[k]);
            if (a_v[k] == 1) chk($sformatf("seq_word_%0d", k), int'(ucode_out), a_w[k]);
            if (k == 5) chk("seq_next_op", int'(op_cur), 8'h22);
            if (k == 0) opcode_in = 8'h22;
            if (k == 5) run = 1'b0;
        end
        repeat (3) @(negedge clk);

        // ---------------- B: wait on source 0 ----------------
        do_reset();
        opcode_in = 8'h21;
        run       = 1'b1;
        busy      = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("stall_stalled_%0d", k), int'(stalled), 1);
            chk($sformatf("stall_valid_%0d", k), int'(ucode_valid), 0);
            chk($sformatf("stall_cycle_%0d", k), int'(cycle), 0);
            busy[1] = ~busy[1];
            if (k == 0) run = 1'b0;
        end
        busy[0] = 1'b0;
        @(negedge clk);
        chk("stall_issue_valid", int'(ucode_valid), 1);
        chk("stall_issue_word", int'(ucode_out), 6);
        chk("stall_issue_cycle", int'(cycle), 1);
        busy[1] = ~busy[1];
        @(negedge clk);
        chk("stall_end_done", int'(instr_done), 1);
        chk("stall_end_valid", int'(ucode_valid), 0);
        @(negedge clk);
        chk("stall_after_valid", int'(ucode_valid), 0);

        // ---------------- C: halt wins over wait ----------------
        do_reset();
        opcode_in = 8'h30;
        run       = 1'b1;
        busy      = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        chk("halt_valid", int'(ucode_valid), 1);
        chk("halt_word", int'(ucode_out), 1);
        chk("halt_halted", int'(halted), 1);
        opcode_in = 8'h20;
        busy      = 4'd0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("halt_hold_valid_%0d", k), int'(ucode_valid), 0);
            chk($sformatf("halt_sticky_%0d", k), int'(halted), 1);
        end
        chk("halt_op_held", int'(op_cur), 8'h30);

        // ---------------- D: watchdog ----------------
        do_reset();
        opcode_in = 8'h31;
        run       = 1'b1;
        nwords    = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ucode_valid) nwords++;
            if (fault) break;
        end
        chk("wd_words", nwords, 48);
        chk("wd_fault", int'(fault), 1);
        chk("wd_cycle", int'(cycle), 48);
        chk("wd_valid", int'(ucode_valid), 0);
        repeat (3) @(negedge clk);
        chk("wd_fault_sticky", int'(fault), 1);
        chk("wd_valid_after", int'(ucode_valid), 0);
        reset = 1'b1;
        run   = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("wd_reset_fault", int'(fault), 0);
        chk("wd_reset_cycle", int'(cycle), 0);

        // ---------------- E: reset at cycle 3 ----------------
        do_reset();
        opcode_in = 8'h23;
        run       = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("mrst_cycle_%0d", k), int'(cycle), k);
        end
        reset     = 1'b1;
        opcode_in = 8'h22;
        @(negedge clk);
        chk("mrst_op_cur", int'(op_cur), 0);
        chk("mrst_cycle", int'(cycle), 0);
        chk("mrst_ucode_out", int'(ucode_out), 0);
        chk("mrst_valid", int'(ucode_valid), 0);
        chk("mrst_done", int'(instr_done), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("mrst_restart_op", int'(op_cur), 8'h22);
        chk("mrst_restart_cycle", int'(cycle), 0);
        run = 1'b0;
        @(negedge clk);
        chk("mrst_restart_word", int'(ucode_out), 9);
        chk("mrst_restart_valid", int'(ucode_valid), 1);

        // ---------------- F: run dropped at cycle 1 ----------------
        do_reset();
        opcode_in = 8'h24;
        run       = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rund_w0", int'(ucode_out), 20);
        chk("rund_c1", int'(cycle), 1);
        run       = 1'b0;
        opcode_in = 8'h55;
        @(negedge clk);
        chk("rund_w1", int'(ucode_out), 21);
        chk("rund_v1", int'(ucode_valid), 1);
        @(negedge clk);
        chk("rund_w2", int'(ucode_out), 22);
        chk("rund_v2", int'(ucode_valid), 1);
        @(negedge clk);
        chk("rund_done", int'(instr_done), 1);
        @(negedge clk);
        chk("rund_idle_done", int'(instr_done), 0);
        chk("rund_idle_valid", int'(ucode_valid), 0);
        chk("rund_op_held", int'(op_cur), 8'h24);
        chk("rund_idle_cycle", int'(cycle), 0);

        // ---------------- random phase with scoreboard ----------------
        do_reset();
        exp_q.delete();
        sb_on     = 1'b1;
        rand_busy = 1'b1;
        op = 8'h40 | 8'($urandom_range(0, 15));
        push_prog(op);
        opcode_in = op;
        run       = 1'b1;
        @(negedge clk);
        for (int k = 1; k < 40; k++) begin
            op = 8'h40 | 8'($urandom_range(0, 15));
            push_prog(op);
            opcode_in = op;
            wait_done("rand_done");
        end
        run = 1'b0;
        wait_done("rand_last_done");
        repeat (4) @(negedge clk);
        chk("rand_queue_drained", exp_q.size(), 0);
        sb_on     = 1'b0;
        rand_busy = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule

// File: doc/microcode_sequencer.md
Name: microcode_sequencer

Overview:
- Sequential successor to the combinational opcode-to-microcode lookup.
- Owns the per-instruction cycle counter and the instruction state machine. Presents `cycle` to the lookup and issues one registered microcode word per clock.
- Stalls on per-source wait conditions, terminates on the end code, halts on the halt code, and faults on runaway sequences.
- Sits between the instruction register/fetch logic and the datapath control decoder.

Parameters:
- OPW, 8, opcode width.
- UCW, 6, microcode word width.
- CYCW, 6, cycle counter width.
- NWAIT, 4, number of independent wait sources (GPU, BCD/DD, MS timer, US timer, frame timer, ...).
- END_CODE, 0, microcode value meaning end of instruction.
- HLT_CODE, 1, microcode value meaning stop the CPU clock.
- MAX_STEPS, 48, cycle index at which an unterminated sequence is a fault; must be at most 2^CYCW-1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- run  in  1  permission to start or continue instructions
- opcode_in  in  OPW  opcode from the instruction register
- ucode_in  in  UCW  lookup result for (op_cur, cycle)
- wait_en  in  NWAIT  decode of ucode_in: bit i set means this word waits on source i
- busy  in  NWAIT  source i busy
- op_cur  out  OPW  latched opcode driving the lookup
- cycle  out  CYCW  current step index driving the lookup
- ucode_out  out  UCW  issued microcode word
- ucode_valid  out  1  ucode_out is valid this cycle
- instr_done  out  1  one-cycle pulse when END_CODE is reached
- stalled  out  1  current step is blocked by a wait condition
- halted  out  1  HLT_CODE has been issued (sticky)
- fault  out  1  watchdog tripped (sticky)

Behaviour:
- Reset: synchronous, active-high, applies on the clock edge. All registers clear on that edge even mid-instruction; no partial word is issued afterwards.
- Reset values: state=IDLE, op_cur=0, cycle=0, ucode_out=END_CODE, and ucode_valid, instr_done, stalled, halted, fault all 0.
- The lookup is combinational on (op_cur, cycle). ucode_out and ucode_valid are registered, so each issued word appears one clock after its cycle index was presented.
- States:
  - IDLE: cycle=0, ucode_valid=0. If run=1, latch op_cur<=opcode_in, cycle<=0, go to EXEC.
  - EXEC: evaluate the current word ucode_in. blk = |(wait_en & busy), and `stalled` is blk combinationally. Priority order:
    1. ucode_in==END_CODE: ucode_valid<=0, instr_done<=1, cycle<=0. If run=1, re-latch op_cur<=opcode_in and stay in EXEC; else go to IDLE. The END step costs exactly one bubble cycle.
    2. ucode_in==HLT_CODE: ucode_out<=HLT_CODE, ucode_valid<=1, halted<=1, go to HALT.
    3. blk=1: hold cycle, ucode_valid<=0. A wait word is issued only once, on the cycle its sources are all non-busy.
    4. cycle==MAX_STEPS: fault<=1, ucode_valid<=0, go to FAULT.
    5. Otherwise: ucode_out<=ucode_in, ucode_valid<=1, cycle<=cycle+1.
  - HALT: ucode_valid=0 from the next cycle. Ignores run and opcode_in. Exits only by reset.
  - FAULT: ucode_valid=0. Exits only by reset.
- run deasserted mid-instruction: the current instruction completes; the sequencer goes to IDLE at END.
- END_CODE reached while a wait source is busy: END takes priority and instr_done still pulses.
- Simultaneous HLT_CODE and blk=1: HLT takes priority.
- cycle never wraps. The watchdog stops it at MAX_STEPS.
- instr_done is high only in the cycle after END_CODE is evaluated.
- busy bits whose wait_en bit is 0 are ignored.

Test Plan:
- Opcode with a 4-word sequence (2,3,4,5) then END, run=1 held:
  - cycle steps 0,1,2,3,4.
  - ucode_out=2,3,4,5 on consecutive clocks, each with valid=1.
  - At the END step: instr_done pulses, valid=0 for exactly one clock.
  - The next opcode is latched on that edge and its first word appears two clocks after END.
- Word 6 with wait_en=0001 and busy[0] high for 5 clocks:
  - stalled=1 and valid=0 for 5 clocks, cycle held.
  - Word 6 is issued once on the 6th clock.
  - busy[1] toggling throughout has no effect.
- HLT_CODE at cycle 0 with busy[0]=1 and wait_en=0001:
  - HLT issued with valid=1; halted=1 and stays 1.
  - Further opcodes are ignored until reset.
- Sequence with no END, MAX_STEPS=48:
  - 48 words are issued, then fault=1 with cycle=48 and valid=0 thereafter.
  - Reset clears fault and returns to IDLE.
- Reset asserted at cycle 3 of a 6-step sequence: on the next edge all outputs take their reset values; with run=1 a new opcode starts at cycle 0.
- run dropped at cycle 1 of a 3-word sequence: the remaining words are issued, instr_done pulses, and the sequencer goes to IDLE with op_cur held.
